// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl
// Run-control sequencer between the DE2 pushbuttons/switches and the
// pipelined CPU core. It debounces the keys, produces the core reset pulse
// and gates core progress through a global enable. It supports free run,
// halt, single step and one PC breakpoint.
//
// Ports
//   clk         system clock (CLOCK_50 domain)
//   res_n       asynchronous active-low reset
//   key_rst_n   raw pushbutton, active-low: restart the CPU
//   key_run_n   raw pushbutton, active-low: toggle run/halt
//   key_step_n  raw pushbutton, active-low: single step from halt
//   bp_en       breakpoint enable switch
//   bp_addr     breakpoint PC
//   pc_f        current fetch PC from the core
//   cpu_res     active-high reset to the core
//   cpu_en      core advance enable (0 = whole pipeline holds)
//   state       00 RESET, 01 HALT, 10 RUN, 11 STEP
//   bp_hit      sticky: the last halt was caused by the breakpoint
//   run_cycles  number of cycles the core was enabled (wraps)
// ---------------------------------------------------------------------------
module cpu_run_ctrl #(
  parameter logic [15:0] DEB_CYCLES = 16'd50000,
  parameter int          RST_CYCLES = 8,
  parameter int          PC_W       = 32,
  parameter logic        AUTO_RUN   = 1'b0
) (
  input  logic            clk,
  input  logic            res_n,
  input  logic            key_rst_n,
  input  logic            key_run_n,
  input  logic            key_step_n,
  input  logic            bp_en,
  input  logic [PC_W-1:0] bp_addr,
  input  logic [PC_W-1:0] pc_f,
  output logic            cpu_res,
  output logic            cpu_en,
  output logic [1:0]      state,
  output logic            bp_hit,
  output logic [31:0]     run_cycles
);

  typedef enum logic [1:0] {
    ST_RESET = 2'b00,
    ST_HALT  = 2'b01,
    ST_RUN   = 2'b10,
    ST_STEP  = 2'b11
  } state_e;

  localparam logic [15:0] DEB_LAST = DEB_CYCLES - 16'd1;
  localparam logic [7:0]  RST_LAST = 8'(RST_CYCLES - 1);

  // Key index: 0 = reset, 1 = run, 2 = step.
  localparam int K_RST  = 0;
  localparam int K_RUN  = 1;
  localparam int K_STEP = 2;

  logic [2:0]  key_raw;
  logic [2:0]  sync1_q;
  logic [2:0]  sync2_q;
  logic [2:0]  deb_q;
  logic [2:0]  press_q;
  logic [15:0] deb_cnt_q [3];

  state_e      state_q;
  logic [7:0]  rst_cnt_q;
  logic        cpu_res_q;
  logic        bp_hit_q;
  logic        resume_q;
  logic [31:0] run_cycles_q;
  logic [31:0] run_cycles_d;

  logic        bp_match;
  logic        brk;

  assign key_raw = {key_step_n, key_run_n, key_rst_n};

  // Two-flop synchronizer followed by a per-key stability counter. The
  // debounced level only flips after DEB_CYCLES consecutive samples that
  // disagree with it; any agreeing sample restarts the count, so short
  // glitches are swallowed. A press is the registered 1->0 flip.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      deb_q   <= '1;
      press_q <= '0;
      for (int k = 0; k < 3; k++) begin
        deb_cnt_q[k] <= '0;
      end
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      for (int k = 0; k < 3; k++) begin
        press_q[k] <= 1'b0;
        if (sync2_q[k] == deb_q[k]) begin
          deb_cnt_q[k] <= '0;
        end else if (deb_cnt_q[k] == DEB_LAST) begin
          deb_q[k]     <= sync2_q[k];
          deb_cnt_q[k] <= '0;
          press_q[k]   <= ~sync2_q[k];
        end else begin
          deb_cnt_q[k] <= deb_cnt_q[k] + 16'd1;
        end
      end
    end
  end

  // The breakpoint compare is combinational so the core is stopped in the
  // very cycle the fetch PC matches. resume_q masks it for the first RUN
  // cycle after a resume, otherwise resuming at the breakpoint PC would
  // re-trap forever.
  assign bp_match = bp_en && (pc_f == bp_addr);
  assign brk      = (state_q == ST_RUN) && bp_match && !resume_q;
  assign cpu_en   = (state_q == ST_STEP) || ((state_q == ST_RUN) && !brk);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q   <= ST_RESET;
      rst_cnt_q <= '0;
      cpu_res_q <= 1'b1;
      bp_hit_q  <= 1'b0;
      resume_q  <= 1'b0;
    end else begin
      resume_q <= 1'b0;
      // A reset press overrides every other event, in every state.
      if (press_q[K_RST]) begin
        state_q   <= ST_RESET;
        rst_cnt_q <= '0;
        cpu_res_q <= 1'b1;
        bp_hit_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_RESET: begin
            if (rst_cnt_q == RST_LAST) begin
              state_q   <= AUTO_RUN ? ST_RUN : ST_HALT;
              rst_cnt_q <= '0;
              cpu_res_q <= 1'b0;
            end else begin
              rst_cnt_q <= rst_cnt_q + 8'd1;
            end
          end
          ST_HALT: begin
            // Run wins over step when both arrive together.
            if (press_q[K_RUN]) begin
              state_q  <= ST_RUN;
              bp_hit_q <= 1'b0;
              resume_q <= 1'b1;
            end else if (press_q[K_STEP]) begin
              state_q <= ST_STEP;
            end
          end
          ST_STEP: begin
            state_q <= ST_HALT;
          end
          ST_RUN: begin
            // Breakpoint takes precedence over a simultaneous run press.
            if (brk) begin
              state_q  <= ST_HALT;
              bp_hit_q <= 1'b1;
            end else if (press_q[K_RUN]) begin
              state_q <= ST_HALT;
            end
          end
        endcase
      end
    end
  end

  // Only res_n clears the counter, so it accumulates across CPU restarts.
  always_comb begin
    run_cycles_d = run_cycles_q;
    if (cpu_en && !cpu_res_q) begin
      run_cycles_d = run_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      run_cycles_q <= '0;
    end else begin
      run_cycles_q <= run_cycles_d;
    end
  end

  assign state      = state_q;
  assign cpu_res    = cpu_res_q;
  assign bp_hit     = bp_hit_q;
  assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_ctrl
// Directed bench for cpu_run_ctrl (DEB_CYCLES=4, RST_CYCLES=8, AUTO_RUN=0).
// The stimulus process schedules expected output values for specific clock
// cycles into a queue; an independent monitor compares them shortly after
// each falling edge in the scheduled cycle.
// ---------------------------------------------------------------------------
module tb_cpu_run_ctrl;

  localparam int F_STATE = 0;
  localparam int F_RES   = 1;
  localparam int F_EN    = 2;
  localparam int F_HIT   = 3;
  localparam int F_RC    = 4;

  logic        clk        = 1'b0;
  logic        res_n      = 1'b0;
  logic        key_rst_n  = 1'b1;
  logic        key_run_n  = 1'b1;
  logic        key_step_n = 1'b1;
  logic        bp_en      = 1'b0;
  logic [31:0] bp_addr    = 32'h0;
  logic [31:0] pc_f       = 32'h0;
  logic        cpu_res;
  logic        cpu_en;
  logic [1:0]  state;
  logic        bp_hit;
  logic [31:0] run_cycles;

  cpu_run_ctrl #(
    .DEB_CYCLES (16'd4),
    .RST_CYCLES (8),
    .PC_W       (32),
    .AUTO_RUN   (1'b0)
  ) dut (
    .clk        (clk),
    .res_n      (res_n),
    .key_rst_n  (key_rst_n),
    .key_run_n  (key_run_n),
    .key_step_n (key_step_n),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc_f       (pc_f),
    .cpu_res    (cpu_res),
    .cpu_en     (cpu_en),
    .state      (state),
    .bp_hit     (bp_hit),
    .run_cycles (run_cycles)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          when;
    int          fld;
    logic [31:0] val;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_id   = 0;

  task automatic expect_at(input int when, input int fld, input logic [31:0] val);
    exp_t e;
    e.when = when;
    e.fld  = fld;
    e.val  = val;
    e.id   = n_id;
    n_id++;
    exp_q.push_back(e);
  endtask

  task automatic expect_all(input int when, input logic [1:0] st, input logic res,
                            input logic en, input logic hit, input logic [31:0] rc);
    expect_at(when, F_STATE, {30'd0, st});
    expect_at(when, F_RES,   {31'd0, res});
    expect_at(when, F_EN,    {31'd0, en});
    expect_at(when, F_HIT,   {31'd0, hit});
    expect_at(when, F_RC,    rc);
  endtask

  function automatic logic [31:0] observe(input int fld);
    case (fld)
      F_STATE: return {30'd0, state};
      F_RES:   return {31'd0, cpu_res};
      F_EN:    return {31'd0, cpu_en};
      F_HIT:   return {31'd0, bp_hit};
      default: return run_cycles;
    endcase
  endfunction

  function automatic string fname(input int fld);
    case (fld)
      F_STATE: return "state";
      F_RES:   return "cpu_res";
      F_EN:    return "cpu_en";
      F_HIT:   return "bp_hit";
      default: return "run_cycles";
    endcase
  endfunction

  // Monitor: compare every expectation scheduled for the current cycle.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].when == cyc) begin
          n_chk++;
          if (observe(exp_q[i].fld) === exp_q[i].val) begin
            n_pass++;
          end else begin
            $display("FAIL chk%0d %s cyc=%0d got=%0h expected=%0h",
                     exp_q[i].id, fname(exp_q[i].fld), cyc,
                     observe(exp_q[i].fld), exp_q[i].val);
          end
          exp_q.delete(i);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold the selected keys low for 10 cycles, then release for 10 cycles so
  // the release has fully debounced before the next press.
  task automatic press_keys(input logic r, input logic u, input logic s);
    key_rst_n  = ~r;
    key_run_n  = ~u;
    key_step_n = ~s;
    tick(10);
    key_rst_n  = 1'b1;
    key_run_n  = 1'b1;
    key_step_n = 1'b1;
    tick(10);
  endtask

  int t;

  initial begin
    // Power-on reset state.
    tick(1);
    expect_all(cyc, 2'b00, 1'b1, 1'b0, 1'b0, 32'd0);
    tick(2);
    res_n = 1'b1;
    t = cyc;
    // cpu_res held for exactly 8 cycles after release, then HALT.
    expect_at(t + 1, F_RES, 32'd1);
    expect_at(t + 7, F_STATE, 32'd0);
    expect_at(t + 7, F_RES, 32'd1);
    expect_all(t + 8, 2'b01, 1'b0, 1'b0, 1'b0, 32'd0);
    tick(12);

    n_chk++;
    if (state === 2'b01) n_pass++;
    else $display("FAIL direct state after reset got=%0h", state);
    n_chk++;
    if (cpu_en === 1'b0) n_pass++;
    else $display("FAIL direct cpu_en after reset got=%0h", cpu_en);
    n_chk++;
    if (run_cycles === 32'd0) n_pass++;
    else $display("FAIL direct run_cycles after reset got=%0h", run_cycles);

    // 3-cycle glitch on run key: no event.
    t = cyc;
    expect_at(t + 12, F_STATE, 32'd1);
    expect_at(t + 12, F_EN, 32'd0);
    key_run_n = 1'b0;
    tick(3);
    key_run_n = 1'b1;
    tick(14);

    // Real run press: pulse after 2+4 edges, RUN on the next.
    t = cyc;
    expect_at(t + 6, F_STATE, 32'd1);
    expect_all(t + 7, 2'b10, 1'b0, 1'b1, 1'b0, 32'd0);
    expect_at(t + 8, F_RC, 32'd1);
    expect_at(t + 9, F_RC, 32'd2);
    press_keys(1'b0, 1'b1, 1'b0);

    // Run press while running: back to HALT after 20 enabled cycles.
    t = cyc;
    expect_at(t + 6, F_STATE, 32'd2);
    expect_all(t + 7, 2'b01, 1'b0, 1'b0, 1'b0, 32'd20);
    press_keys(1'b0, 1'b1, 1'b0);

    // Three single steps.
    for (int k = 0; k < 3; k++) begin
      t = cyc;
      expect_all(t + 7, 2'b11, 1'b0, 1'b1, 1'b0, 32'(20 + k));
      expect_all(t + 8, 2'b01, 1'b0, 1'b0, 1'b0, 32'(21 + k));
      press_keys(1'b0, 1'b0, 1'b1);
    end

    // Breakpoint at 0x10 while the core walks 0,4,8,C,10.
    bp_en   = 1'b1;
    bp_addr = 32'h10;
    pc_f    = 32'h0;
    t = cyc;
    expect_at(t + 10, F_STATE, 32'd2);
    expect_at(t + 10, F_EN, 32'd1);
    expect_at(t + 11, F_STATE, 32'd2);
    expect_at(t + 11, F_EN, 32'd0);
    expect_all(t + 12, 2'b01, 1'b0, 1'b0, 1'b1, 32'd27);
    for (int i = 0; i < 20; i++) begin
      key_run_n = (i < 10) ? 1'b0 : 1'b1;
      if (i <= 7)       pc_f = 32'h0;
      else if (i <= 11) pc_f = 32'((i - 7) * 4);
      else              pc_f = 32'h10;
      tick(1);
    end

    n_chk++;
    if (bp_hit === 1'b1) n_pass++;
    else $display("FAIL direct bp_hit after breakpoint got=%0h", bp_hit);
    n_chk++;
    if (state === 2'b01) n_pass++;
    else $display("FAIL direct state after breakpoint got=%0h", state);

    // Resume at the breakpoint PC: first cycle masked, core moves on.
    t = cyc;
    expect_at(t + 6, F_HIT, 32'd1);
    expect_at(t + 7, F_STATE, 32'd2);
    expect_at(t + 7, F_EN, 32'd1);
    expect_at(t + 7, F_HIT, 32'd0);
    expect_at(t + 8, F_EN, 32'd1);
    expect_at(t + 9, F_RC, 32'd29);
    for (int i = 0; i < 20; i++) begin
      key_run_n = (i < 10) ? 1'b0 : 1'b1;
      pc_f = (i <= 7) ? 32'h10 : 32'(16 + 4 * (i - 7));
      tick(1);
    end

    // Reset, run and step together while running: reset wins.
    bp_en = 1'b0;
    t = cyc;
    expect_at(t + 6, F_STATE, 32'd2);
    expect_all(t + 7, 2'b00, 1'b1, 1'b0, 1'b0, 32'd47);
    expect_at(t + 14, F_STATE, 32'd0);
    expect_at(t + 14, F_RES, 32'd1);
    expect_all(t + 15, 2'b01, 1'b0, 1'b0, 1'b0, 32'd47);
    press_keys(1'b1, 1'b1, 1'b1);

    // Run and step together from HALT: run wins.
    t = cyc;
    expect_at(t + 7, F_STATE, 32'd2);
    expect_at(t + 7, F_EN, 32'd1);
    press_keys(1'b0, 1'b1, 1'b1);

    // Counter wrap while running.
    t = cyc;
    expect_at(t + 1, F_RC, 32'hFFFF_FFFF);
    expect_at(t + 2, F_RC, 32'h0000_0000);
    expect_at(t + 3, F_RC, 32'h0000_0001);
    force dut.run_cycles_q = 32'hFFFF_FFFE;
    #1;
    release dut.run_cycles_q;
    tick(5);

    n_chk++;
    if (run_cycles === 32'd3) n_pass++;
    else $display("FAIL direct run_cycles after wrap got=%0h", run_cycles);
    n_chk++;
    if (state === 2'b10) n_pass++;
    else $display("FAIL direct state after wrap got=%0h", state);

    // Any expectation never reached by the monitor is a failure.
    while (exp_q.size() > 0) begin
      n_chk++;
      $display("FAIL chk%0d %s never checked (cyc=%0d)",
               exp_q[0].id, fname(exp_q[0].fld), exp_q[0].when);
      void'(exp_q.pop_front());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
